// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode map, FSM state encoding and default width for the sequential ALU
package ula_pkg;

    localparam int W_DEFAULT = 16;
    localparam int OPW       = 5;

    localparam logic [4:0] OP_MOV  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic {
        OCIOSO = 1'b0,
        CALC   = 1'b1
    } estado_t;

endpackage

// File: rtl/ula_multdiv_iter.sv
// rtl/ula_multdiv_iter.sv - W-iteration shift-add multiplier / restoring divider on a shared datapath
module ula_multdiv_iter
    import ula_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   produto,
    output logic [W-1:0]     quociente,
    output logic [W-1:0]     resto
);

    localparam int CW = $clog2(W) + 1;

    // acc is the product high half (MUL) or the partial remainder (DIV);
    // shreg is the multiplier being consumed (MUL) or dividend/quotient (DIV)
    logic             running;
    logic             div_mode;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     acc;
    logic [W-1:0]     shreg;
    logic [W-1:0]     operand_b;
    logic [W-1:0]     acc_nxt;
    logic [W-1:0]     sh_nxt;
    logic [W:0]       sum;
    logic [W:0]       shifted;
    logic [W:0]       diff;

    // One iteration step; outputs expose the post-step value so the top can
    // capture the final result on the same edge as the last iteration
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, (shreg[0] ? operand_b : {W{1'b0}})};
        shifted = {acc, shreg[W-1]};
        diff    = shifted - {1'b0, operand_b};
        acc_nxt = acc;
        sh_nxt  = shreg;
        if (div_mode) begin
            if (shifted >= {1'b0, operand_b}) begin
                acc_nxt = diff[W-1:0];
                sh_nxt  = {shreg[W-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[W-1:0];
                sh_nxt  = {shreg[W-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[W:1];
            sh_nxt  = {sum[0], shreg[W-1:1]};
        end
        done      = running && (cnt == CW'(W - 1));
        produto   = {acc_nxt, sh_nxt};
        quociente = sh_nxt;
        resto     = acc_nxt;
    end

    // Load operands on start, then advance one iteration per edge for W edges
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            running   <= 1'b0;
            div_mode  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            shreg     <= '0;
            operand_b <= '0;
        end else if (start) begin
            running   <= 1'b1;
            div_mode  <= is_div;
            cnt       <= '0;
            acc       <= '0;
            shreg     <= a;
            operand_b <= b;
        end else if (running) begin
            acc   <= acc_nxt;
            shreg <= sh_nxt;
            cnt   <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_sequencial.sv
// rtl/ula_sequencial.sv - registered ALU with start/done handshake and iterative MUL/DIV
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int W   = W_DEFAULT,
    parameter int OPW = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inicio,
    input  logic [W-1:0]     operando1,
    input  logic [W-1:0]     operando2,
    input  logic [OPW-1:0]   opcode,
    output logic [2*W-1:0]   resultado,
    output logic             pronto,
    output logic             ocupado,
    output logic             erro_div,
    output logic             erro_opcode
);

    estado_t          estado;
    logic             op_div;
    logic             aceita;
    logic             iterativa;
    logic [2*W-1:0]   ext1;
    logic [2*W-1:0]   ext2;
    logic [2*W-1:0]   res_comb;
    logic             ediv_comb;
    logic             eop_comb;
    logic             md_done;
    logic [2*W-1:0]   md_produto;
    logic [W-1:0]     md_quociente;
    logic [W-1:0]     md_resto;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    // Single-cycle datapath plus the decision whether a request goes iterative
    always_comb begin
        ext1      = {{W{1'b0}}, operando1};
        ext2      = {{W{1'b0}}, operando2};
        res_comb  = '0;
        ediv_comb = 1'b0;
        eop_comb  = 1'b0;
        iterativa = (opcode == OP_MUL || opcode == OP_DIV) && (operando2 != '0);
        aceita    = inicio && (estado == OCIOSO);
        case (opcode)
            OP_MOV:  res_comb = ext1;
            OP_ADD:  res_comb = ext1 + ext2;
            OP_SUB:  res_comb = ext1 - ext2;
            OP_MUL:  res_comb = '0;
            OP_DIV: begin
                res_comb  = {operando1, ONES};
                ediv_comb = 1'b1;
            end
            OP_AND:  res_comb = ext1 & ext2;
            OP_NAND: res_comb = {ONES, ~(operando1 & operando2)};
            OP_OR:   res_comb = ext1 | ext2;
            OP_XOR:  res_comb = ext1 ^ ext2;
            OP_CMP: begin
                if (operando1 == operando2)     res_comb = '0;
                else if (operando1 > operando2) res_comb = {{(2*W-1){1'b0}}, 1'b1};
                else                            res_comb = {ONES, ONES};
            end
            OP_NOT:  res_comb = {ONES, ~operando1};
            default: eop_comb = 1'b1;
        endcase
    end

    ula_multdiv_iter #(.W(W)) u_multdiv (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (aceita && iterativa),
        .is_div    (opcode == OP_DIV),
        .a         (operando1),
        .b         (operando2),
        .done      (md_done),
        .produto   (md_produto),
        .quociente (md_quociente),
        .resto     (md_resto)
    );

    // Control FSM and output registers; pronto is a one-edge pulse per request
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            op_div      <= 1'b0;
            resultado   <= '0;
            pronto      <= 1'b0;
            ocupado     <= 1'b0;
            erro_div    <= 1'b0;
            erro_opcode <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        if (iterativa) begin
                            estado  <= CALC;
                            ocupado <= 1'b1;
                            op_div  <= (opcode == OP_DIV);
                        end else begin
                            resultado   <= res_comb;
                            erro_div    <= ediv_comb;
                            erro_opcode <= eop_comb;
                            pronto      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (md_done) begin
                        resultado   <= op_div ? {md_resto, md_quociente} : md_produto;
                        erro_div    <= 1'b0;
                        erro_opcode <= 1'b0;
                        pronto      <= 1'b1;
                        ocupado     <= 1'b0;
                        estado      <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_sequencial.sv
// tb/tb_ula_sequencial.sv - randomized self-checking bench for ula_sequencial
module tb_ula_sequencial;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          inicio = 1'b0;
    logic [W-1:0]  operando1 = '0;
    logic [W-1:0]  operando2 = '0;
    logic [4:0]    opcode = '0;
    logic [2*W-1:0] resultado;
    logic          pronto;
    logic          ocupado;
    logic          erro_div;
    logic          erro_opcode;

    int total = 0;
    int bad   = 0;

    ula_sequencial #(.W(W), .OPW(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .inicio      (inicio),
        .operando1   (operando1),
        .operando2   (operando2),
        .opcode      (opcode),
        .resultado   (resultado),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .erro_div    (erro_div),
        .erro_opcode (erro_opcode)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference: result, flags and cycles between accept and pronto
    function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] r, output logic ed, output logic eo,
                                  output int lat);
        r = '0; ed = 1'b0; eo = 1'b0; lat = 0;
        case (op)
            5'd2:  r = 32'(a);
            5'd4:  r = 32'(a) + 32'(b);
            5'd5:  r = 32'(a) - 32'(b);
            5'd6: begin
                r = 32'(a) * 32'(b);
                lat = (b != 0) ? W : 0;
            end
            5'd7: begin
                if (b == 0) begin
                    r = {a, 16'hFFFF};
                    ed = 1'b1;
                end else begin
                    r = {16'(a % b), 16'(a / b)};
                    lat = W;
                end
            end
            5'd8:  r = 32'(a & b);
            5'd9:  r = {16'hFFFF, ~(a & b)};
            5'd10: r = 32'(a | b);
            5'd11: r = 32'(a ^ b);
            5'd12: r = (a == b) ? 32'd0 : ((a > b) ? 32'd1 : 32'hFFFF_FFFF);
            5'd13: r = {16'hFFFF, ~a};
            default: eo = 1'b1;
        endcase
    endfunction

    // Issue one request (called off-edge), wait for pronto and check everything
    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit poke, input bit chk_tail);
        logic [31:0] er;
        logic ed, eo;
        int lat, cyc, ocu;
        model(op, a, b, er, ed, eo, lat);
        opcode = op; operando1 = a; operando2 = b; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0;
        operando1 = 16'($urandom);
        operando2 = 16'($urandom);
        opcode    = 5'($urandom);
        cyc = 0; ocu = 0;
        while (!pronto && cyc < 40) begin
            if (ocupado) ocu++;
            if (poke && cyc == 3) begin
                opcode = 5'd4; operando1 = 16'd1; operando2 = 16'd1; inicio = 1'b1;
            end
            if (poke && cyc == 5) inicio = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        inicio = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        check("busy_cycles", 32'(ocu), 32'(lat));
        check("ocupado_end", {31'b0, ocupado}, 32'd0);
        check("resultado", resultado, er);
        check("erro_div", {31'b0, erro_div}, {31'b0, ed});
        check("erro_opcode", {31'b0, erro_opcode}, {31'b0, eo});
        if (chk_tail) begin
            @(posedge clock); #1;
            check("pronto_pulse", {31'b0, pronto}, 32'd0);
            check("resultado_hold", resultado, er);
        end
    endtask

    initial begin
        logic [4:0] rop;
        logic [15:0] ra, rb;

        repeat (2) @(posedge clock);
        #1;
        check("rst_resultado", resultado, 32'd0);
        check("rst_pronto", {31'b0, pronto}, 32'd0);
        check("rst_ocupado", {31'b0, ocupado}, 32'd0);
        check("rst_flags", {30'b0, erro_div, erro_opcode}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op(5'd4, 16'hFFFF, 16'h0001, 0, 1);
        check("add_carry", resultado, 32'h0001_0000);
        run_op(5'd6, 16'hFFFF, 16'hFFFF, 1, 1);
        check("mul_max", resultado, 32'hFFFE_0001);
        run_op(5'd7, 16'd100, 16'd7, 0, 1);
        check("div_100_7", resultado, 32'h0002_000E);
        run_op(5'd7, 16'h1234, 16'h0000, 0, 1);
        check("div_zero", resultado, 32'h1234_FFFF);
        run_op(5'd12, 16'd5, 16'd9, 0, 1);
        run_op(5'd12, 16'd9, 16'd5, 0, 1);
        run_op(5'd12, 16'd7, 16'd7, 0, 1);
        run_op(5'd11, 16'h00FF, 16'h0F0F, 0, 1);
        run_op(5'd31, 16'h1111, 16'h2222, 0, 1);
        run_op(5'd2, 16'hABCD, 16'h0000, 0, 1);

        // Reset during the 5th iteration of a multiply
        opcode = 5'd6; operando1 = 16'd7; operando2 = 16'd9; inicio = 1'b1;
        @(posedge clock); #1;
        inicio = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("abort_ocupado", {31'b0, ocupado}, 32'd0);
        check("abort_resultado", resultado, 32'd0);
        check("abort_pronto", {31'b0, pronto}, 32'd0);
        reset_n = 1'b1;
        run_op(5'd4, 16'd2, 16'd3, 0, 1);
        check("after_reset_add", resultado, 32'h0000_0005);
        repeat (20) begin
            @(posedge clock); #1;
            check("no_late_pronto", {31'b0, pronto}, 32'd0);
        end

        // Back-to-back: second request accepted in the pronto cycle
        run_op(5'd6, 16'd3, 16'd4, 0, 0);
        run_op(5'd4, 16'd1, 16'd2, 0, 1);

        for (int i = 0; i < 150; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom >> $urandom_range(0, 15));
            run_op(rop, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
